bpsk_frame_loader: RTL and testbench

BPSK_FRAME_LOADER -- requirements
Module: bpsk_frame_loader

---
 rtl/bpsk_frame_loader.sv | 211 +++++++++++++++++++++
 tb/tb_bpsk_frame_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_frame_loader.sv
// -----------------------------------------------------------------------------
// bpsk_frame_loader
//
// Purpose: loads BPSK frames from an AXI-Stream slave into one of two ping-pong
// BRAM buffers and hands completed buffers to the BPSK controller. The
// controller reports playback progress via interrupt_num; the loader answers
// by pointing dual_ram_num at the next ready buffer (or 00 on underrun).
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast   frame words in (MSB transmitted first)
//   s_axis_tready               high while filling or draining a bad frame
//   interrupt_num[1:0]          controller: bit i high while buffer i+1's last
//                               word is addressed
//   dual_ram_num[1:0]           to controller: 01 buf1, 10 buf2, 00 empty frame
//   ram_clk/en/we/addr/wr_data  write-only BRAM port B (byte addresses)
//   frame_err                   1-cycle pulse on a mis-sized frame
//   underrun                    1-cycle pulse when no buffer is ready at swap
//   frames_played               count of completed playbacks (wraps)
// -----------------------------------------------------------------------------
module bpsk_frame_loader #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned FRAME_WORDS = 38,
   parameter logic [31:0] RAM1_BASE   = 32'h100,
   parameter logic [31:0] RAM2_BASE   = 32'h200
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   input  logic [1:0]              interrupt_num,
   output logic [1:0]              dual_ram_num,
   output logic                    ram_clk,
   output logic                    ram_en,
   output logic [DATA_WIDTH/8-1:0] ram_we,
   output logic [31:0]             ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_wr_data,
   output logic                    frame_err,
   output logic                    underrun,
   output logic [15:0]             frames_played
);

   localparam int unsigned IDX_W = $clog2(FRAME_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

   // Write FSM states
   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_FILL  = 2'd1;
   localparam logic [1:0] W_DRAIN = 2'd2;

   // Per-buffer states
   localparam logic [1:0] B_EMPTY   = 2'd0;
   localparam logic [1:0] B_FILLING = 2'd1;
   localparam logic [1:0] B_READY   = 2'd2;
   localparam logic [1:0] B_PLAYING = 2'd3;

   logic [1:0]       wstate_q, wstate_d;
   logic [1:0][1:0]  buf_q, buf_d;       // [0] = buffer 1, [1] = buffer 2
   logic             sel_q, sel_d;       // buffer being filled: 0 = buf1, 1 = buf2
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [1:0]       dual_q, dual_d;
   logic [1:0]       irq_q;
   logic             frame_err_q, frame_err_d;
   logic             underrun_q, underrun_d;
   logic [15:0]      played_q, played_d;

   logic       xfer;
   logic       fill_xfer;
   logic [1:0] irq_rise;
   logic [1:0] irq_fall;

   // tready is gated by rst so nothing is accepted while reset is held
   assign s_axis_tready = ~rst & ((wstate_q == W_FILL) | (wstate_q == W_DRAIN));
   assign xfer          = s_axis_tvalid & s_axis_tready;
   assign fill_xfer     = xfer & (wstate_q == W_FILL);

   assign irq_rise = interrupt_num & ~irq_q;
   assign irq_fall = ~interrupt_num & irq_q;

   // BRAM write is combinational from the transfer: zero-latency port B
   assign ram_clk     = clk;
   assign ram_en      = fill_xfer;
   assign ram_we      = fill_xfer ? '1 : '0;
   assign ram_addr    = fill_xfer ? ((sel_q ? RAM2_BASE : RAM1_BASE)
                                     + {{(32-IDX_W-2){1'b0}}, idx_q, 2'b00})
                                  : 32'h0;
   assign ram_wr_data = fill_xfer ? s_axis_tdata : '0;

   assign dual_ram_num  = dual_q;
   assign frame_err     = frame_err_q;
   assign underrun      = underrun_q;
   assign frames_played = played_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      wstate_d    = wstate_q;
      buf_d       = buf_q;
      sel_d       = sel_q;
      idx_d       = idx_q;
      dual_d      = dual_q;
      played_d    = played_q;
      frame_err_d = 1'b0;
      underrun_d  = 1'b0;

      // ---- write side: only touches EMPTY/FILLING buffers ----
      case (wstate_q)
         W_IDLE: begin
            if (buf_q[0] == B_EMPTY) begin
               sel_d    = 1'b0;
               buf_d[0] = B_FILLING;
               idx_d    = '0;
               wstate_d = W_FILL;
            end else if (buf_q[1] == B_EMPTY) begin
               sel_d    = 1'b1;
               buf_d[1] = B_FILLING;
               idx_d    = '0;
               wstate_d = W_FILL;
            end
         end
         W_FILL: begin
            if (xfer) begin
               if (idx_q == LAST_IDX) begin
                  if (s_axis_tlast) begin
                     buf_d[sel_q] = B_READY;
                     wstate_d     = W_IDLE;
                  end else begin
                     // Frame too long: drop it and swallow the rest up to tlast
                     frame_err_d  = 1'b1;
                     buf_d[sel_q] = B_EMPTY;
                     wstate_d     = W_DRAIN;
                  end
               end else if (s_axis_tlast) begin
                  frame_err_d  = 1'b1;
                  buf_d[sel_q] = B_EMPTY;
                  wstate_d     = W_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         W_DRAIN: begin
            if (xfer && s_axis_tlast) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase

      // ---- playback side: decisions use pre-update buffer states, so a
      // frame completing in the same cycle as a swap request is not seen
      // until the following cycle (publish then picks it up) ----
      if (dual_q == 2'b00) begin
         if (buf_q[0] == B_READY) begin
            dual_d   = 2'b01;
            buf_d[0] = B_PLAYING;
         end else if (buf_q[1] == B_READY) begin
            dual_d   = 2'b10;
            buf_d[1] = B_PLAYING;
         end
      end else if (irq_rise[0] && dual_q == 2'b01) begin
         played_d = played_q + 16'd1;
         if (buf_q[1] == B_READY) begin
            dual_d   = 2'b10;
            buf_d[1] = B_PLAYING;
         end else begin
            dual_d     = 2'b00;
            underrun_d = 1'b1;
         end
      end else if (irq_rise[1] && !irq_rise[0] && dual_q == 2'b10) begin
         // bit0 wins when both bits rise together
         played_d = played_q + 16'd1;
         if (buf_q[0] == B_READY) begin
            dual_d   = 2'b01;
            buf_d[0] = B_PLAYING;
         end else begin
            dual_d     = 2'b00;
            underrun_d = 1'b1;
         end
      end

      // A falling edge means the controller has finished with that buffer
      if (irq_fall[0]) buf_d[0] = B_EMPTY;
      if (irq_fall[1]) buf_d[1] = B_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_q    <= W_IDLE;
         buf_q       <= {B_EMPTY, B_EMPTY};
         sel_q       <= 1'b0;
         idx_q       <= '0;
         dual_q      <= 2'b00;
         irq_q       <= 2'b00;
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
         played_q    <= 16'd0;
      end else begin
         // NOTE: non-blocking assignments so all state updates from the same edge's values.
         wstate_q    <= wstate_d;
         buf_q       <= buf_d;
         sel_q       <= sel_d;
         idx_q       <= idx_d;
         dual_q      <= dual_d;
         irq_q       <= interrupt_num;
         frame_err_q <= frame_err_d;
         underrun_q  <= underrun_d;
         played_q    <= played_d;
      end
   end

endmodule

// File: tb/tb_bpsk_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_bpsk_frame_loader
//
// Directed bench for bpsk_frame_loader. Expected BRAM writes are pushed to a
// scoreboard queue as words are driven and popped by a monitor whenever the
// DUT raises ram_en. Registered outputs are checked one time unit after the
// clock edge; combinational BRAM outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_bpsk_frame_loader;

   localparam int FRAME_WORDS = 38;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic [1:0]  interrupt_num = 2'b00;
   logic [1:0]  dual_ram_num;
   logic        ram_clk;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wr_data;
   logic        frame_err;
   logic        underrun;
   logic [15:0] frames_played;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ur_cnt = 0;
   wr_t sb[$];

   bpsk_frame_loader dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .interrupt_num (interrupt_num),
      .dual_ram_num  (dual_ram_num),
      .ram_clk       (ram_clk),
      .ram_en        (ram_en),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_wr_data   (ram_wr_data),
      .frame_err     (frame_err),
      .underrun      (underrun),
      .frames_played (frames_played)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write monitor: every BRAM write must match the head of the scoreboard
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (underrun === 1'b1) ur_cnt++;
      if (ram_en === 1'b1) begin
         check("write_expected", 64'(sb.size() != 0), 64'd1);
         check("ram_we", 64'(ram_we), 64'hF);
         if (sb.size() != 0) begin
            wr_t e;
            e = sb.pop_front();
            check("ram_addr", 64'(ram_addr), 64'(e.addr));
            check("ram_wr_data", 64'(ram_wr_data), 64'(e.data));
         end
      end
   end

   // Drive one word and hold it until it is accepted (bounded wait)
   task automatic send(input logic [31:0] d, input logic last,
                       input logic exp_write, input logic [31:0] exp_addr);
      int n;
      n = 0;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      if (exp_write) sb.push_back('{addr: exp_addr, data: d});
      while (s_axis_tready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("tready_timeout", 64'(n), 64'd0);
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // n words, data seed+k, tlast on the last one if with_last; only the
   // first FRAME_WORDS words of a frame can land in RAM
   task automatic frame(input logic [31:0] base, input logic [31:0] seed,
                        input int n, input bit with_last);
      for (int k = 0; k < n; k++)
         send(seed + 32'(k), with_last && (k == n - 1), k < FRAME_WORDS,
              base + 32'(4 * k));
   endtask

   task automatic hold(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      tick();
      tick();
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_ram_en", 64'(ram_en), 64'd0);
      check("rst_ram_addr", 64'(ram_addr), 64'd0);
      check("rst_dual", 64'(dual_ram_num), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_underrun", 64'(underrun), 64'd0);
      check("rst_played", 64'(frames_played), 64'd0);
      rst = 1'b0;
      tick();
      check("idle_to_fill_tready", 64'(s_axis_tready), 64'd1);

      // ---- first frame into buffer 1, published two cycles later ----
      frame(32'h100, 32'h0, FRAME_WORDS, 1'b1);
      check("a_dual_not_yet", 64'(dual_ram_num), 64'd0);
      tick();
      check("a_dual_pub", 64'(dual_ram_num), 64'd1);
      check("a_fill_buf2_tready", 64'(s_axis_tready), 64'd1);

      // ---- underrun: buffer 2 still filling when buffer 1 finishes ----
      interrupt_num = 2'b01;
      tick();
      check("b_dual_underrun", 64'(dual_ram_num), 64'd0);
      check("b_underrun_pulse", 64'(underrun), 64'd1);
      check("b_played", 64'(frames_played), 64'd1);
      tick();
      check("b_underrun_end", 64'(underrun), 64'd0);
      hold(8);
      interrupt_num = 2'b00;
      tick();

      // ---- buffer 2 frame, published immediately since nothing plays ----
      frame(32'h200, 32'h1000, FRAME_WORDS, 1'b1);
      tick();
      check("c_dual_buf2", 64'(dual_ram_num), 64'd2);
      // buffer 1 frame stays READY behind the playing buffer 2
      frame(32'h100, 32'h2000, FRAME_WORDS, 1'b1);
      tick();
      check("c_no_publish", 64'(dual_ram_num), 64'd2);
      check("c_both_busy_tready", 64'(s_axis_tready), 64'd0);
      interrupt_num = 2'b10;
      tick();
      check("c_swap_to_buf1", 64'(dual_ram_num), 64'd1);
      check("c_played2", 64'(frames_played), 64'd2);
      check("c_no_underrun", 64'(underrun), 64'd0);
      hold(9);
      interrupt_num = 2'b00;
      tick();
      check("c_fall_tready_lo", 64'(s_axis_tready), 64'd0);
      tick();
      check("c_fall_tready_hi", 64'(s_axis_tready), 64'd1);
      frame(32'h200, 32'h3000, FRAME_WORDS, 1'b1);
      interrupt_num = 2'b01;
      tick();
      check("c_swap_to_buf2", 64'(dual_ram_num), 64'd2);
      check("c_played3", 64'(frames_played), 64'd3);
      hold(9);
      interrupt_num = 2'b00;
      tick();
      tick();
      check("c_buf1_reusable", 64'(s_axis_tready), 64'd1);

      // ---- short frame: tlast on word 10 ----
      frame(32'h100, 32'h4000, 10, 1'b1);
      check("d_short_err", 64'(frame_err), 64'd1);
      check("d_short_no_pub", 64'(dual_ram_num), 64'd2);
      tick();
      check("d_err_one_cycle", 64'(frame_err), 64'd0);

      // ---- long frame: 45 words, restarts at 0x100 idx 0 ----
      frame(32'h100, 32'h5000, FRAME_WORDS, 1'b0);
      check("e_long_err_at_38", 64'(frame_err), 64'd1);
      for (int k = 0; k < 7; k++)
         send(32'h5000 + 32'(FRAME_WORDS + k), k == 6, 1'b0, 32'h0);
      check("e_idle_after_45", 64'(s_axis_tready), 64'd0);
      check("e_long_no_pub", 64'(dual_ram_num), 64'd2);
      tick();
      check("e_refill_tready", 64'(s_axis_tready), 64'd1);
      check("e_fe_count", 64'(fe_cnt), 64'd2);

      // ---- reset in the middle of a buffer 2 fill ----
      interrupt_num = 2'b10;
      tick();
      check("f_underrun_dual", 64'(dual_ram_num), 64'd0);
      check("f_played4", 64'(frames_played), 64'd4);
      interrupt_num = 2'b00;
      tick();
      frame(32'h100, 32'h6000, FRAME_WORDS, 1'b1);
      tick();
      check("f_pub_buf1", 64'(dual_ram_num), 64'd1);
      frame(32'h200, 32'h7000, 20, 1'b0);
      rst = 1'b1;
      tick();
      check("f_rst_tready", 64'(s_axis_tready), 64'd0);
      check("f_rst_dual", 64'(dual_ram_num), 64'd0);
      check("f_rst_played", 64'(frames_played), 64'd0);
      check("f_rst_ram_en", 64'(ram_en), 64'd0);
      rst = 1'b0;
      tick();
      check("f_post_rst_tready", 64'(s_axis_tready), 64'd1);
      frame(32'h100, 32'h8000, FRAME_WORDS, 1'b1);
      check("f_dual_not_yet", 64'(dual_ram_num), 64'd0);
      tick();
      check("f_pub_after_rst", 64'(dual_ram_num), 64'd1);

      // ---- completion and rising edge in the same cycle ----
      frame(32'h200, 32'h9000, FRAME_WORDS - 1, 1'b0);
      interrupt_num = 2'b01;
      send(32'h9000 + 32'(FRAME_WORDS - 1), 1'b1, 1'b1, 32'h200 + 32'(4 * (FRAME_WORDS - 1)));
      check("g_sim_dual", 64'(dual_ram_num), 64'd0);
      check("g_sim_underrun", 64'(underrun), 64'd1);
      check("g_sim_played", 64'(frames_played), 64'd1);
      tick();
      check("g_late_publish", 64'(dual_ram_num), 64'd2);
      interrupt_num = 2'b00;
      hold(2);

      check("ur_count", 64'(ur_cnt), 64'd3);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
